// File: rtl/icb_apb_dispatcher_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icb_apb_dispatcher_pkg : shared bridge types and address-map constants    |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package icb_apb_dispatcher_pkg;

  localparam int unsigned ICB_ADDR_W  = 32;
  localparam int unsigned ICB_DATA_W  = 32;
  localparam int unsigned SEL_LSB_DEF = 12;
  localparam logic [17:0] BASE_HI_DEF = 18'h04000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef logic [1:0] port_t;

  typedef struct packed {
    logic [ICB_ADDR_W-1:0]   addr;
    logic                    read;
    logic [ICB_DATA_W-1:0]   wdata;
    logic [ICB_DATA_W/8-1:0] wmask;
  } icb_cmd_t;

  function automatic logic [3:0] port_onehot(input port_t p);
    return 4'b0001 << p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icb_apb_dispatcher_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icb_if / apb_if : ICB command/response bus and 4-port shared APB bus      |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface icb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_addr;
  logic                  cmd_read;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface apb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [3:0]             psel;
  logic                   penable;
  logic                   pwrite;
  logic [ADDR_W-1:0]      paddr;
  logic [DATA_W-1:0]      pwdata;
  logic [DATA_W/8-1:0]    pstrb;
  logic [3:0][DATA_W-1:0] prdata;
  logic [3:0]             pready;
  logic [3:0]             pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/icb_apb_addr_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icb_apb_addr_decode : bridge window hit and 2-bit APB port select         |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module icb_apb_addr_decode
  import icb_apb_dispatcher_pkg::*;
#(
  parameter int unsigned                 ADDR_W  = ICB_ADDR_W,
  parameter int unsigned                 SEL_LSB = SEL_LSB_DEF,
  parameter logic [ADDR_W-SEL_LSB-3:0]   BASE_HI = BASE_HI_DEF
) (
  input  logic [ADDR_W-1:SEL_LSB] addr_hi,
  output logic                    hit,
  output port_t                   port
);

  assign hit  = (addr_hi[ADDR_W-1:SEL_LSB+2] == BASE_HI);
  assign port = addr_hi[SEL_LSB+1:SEL_LSB];

endmodule
`default_nettype wire

// File: rtl/icb_apb_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icb_apb_dispatcher : single-outstanding ICB command to 4-port APB master  |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module icb_apb_dispatcher
  import icb_apb_dispatcher_pkg::*;
#(
  parameter int unsigned               ADDR_W  = ICB_ADDR_W,
  parameter int unsigned               DATA_W  = ICB_DATA_W,
  parameter int unsigned               SEL_LSB = SEL_LSB_DEF,
  parameter logic [ADDR_W-SEL_LSB-3:0] BASE_HI = BASE_HI_DEF,
  parameter int unsigned               TIMEOUT = 255
) (
  input  logic  clk,
  input  logic  rst_n,
  icb_if.slave  icb,
  apb_if.master apb
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e                state_q, state_d;
  port_t                 port_q, port_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [3:0]            psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic [DATA_W/8-1:0]   pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  dec_hit;
  port_t                 dec_port;

  icb_apb_addr_decode #(
    .ADDR_W  (ADDR_W),
    .SEL_LSB (SEL_LSB),
    .BASE_HI (BASE_HI)
  ) u_decode (
    .addr_hi (icb.cmd_addr[ADDR_W-1:SEL_LSB]),
    .hit     (dec_hit),
    .port    (dec_port)
  );

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (icb.cmd_valid) begin
          if (dec_hit) begin
            state_d  = ST_SETUP;
            port_d   = dec_port;
            psel_d   = port_onehot(dec_port);
            paddr_d  = icb.cmd_addr;
            pwrite_d = ~icb.cmd_read;
            pwdata_d = icb.cmd_wdata;
            pstrb_d  = icb.cmd_read ? '0 : icb.cmd_wmask;
            cnt_d    = '0;
          end else begin
            // Outside the bridge window: answer with an error, APB untouched.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rdata_d     = '0;
            err_d       = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
        if (apb.pready[port_q]) begin
          state_d     = ST_RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          err_d       = apb.pslverr[port_q];
          rdata_d     = (!pwrite_q && !apb.pslverr[port_q]) ? apb.prdata[port_q] : '0;
        end else if (cnt_q >= TO_LAST) begin
          // Slave too slow: abandon the transfer and report an error.
          state_d     = ST_RESP;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          err_d       = 1'b1;
          rdata_d     = '0;
        end
      end
      ST_RESP: begin
        if (icb.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      port_q      <= '0;
      cnt_q       <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Gated with rst_n so the command port is closed while reset is held.
  assign icb.cmd_ready = rst_n & (state_q == ST_IDLE);
  assign icb.rsp_valid = rsp_valid_q;
  assign icb.rsp_rdata = rdata_q;
  assign icb.rsp_err   = err_q;
  assign apb.psel      = psel_q;
  assign apb.penable   = penable_q;
  assign apb.pwrite    = pwrite_q;
  assign apb.paddr     = paddr_q;
  assign apb.pwdata    = pwdata_q;
  assign apb.pstrb     = pstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_icb_apb_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_icb_apb_dispatcher : directed + random bench with a transaction model  |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_icb_apb_dispatcher;
  import icb_apb_dispatcher_pkg::*;

  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  icb_if #(.ADDR_W(32), .DATA_W(32)) icb ();
  apb_if #(.ADDR_W(32), .DATA_W(32)) apb ();

  icb_apb_dispatcher #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .SEL_LSB (SEL_LSB_DEF),
    .BASE_HI (BASE_HI_DEF),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .icb   (icb),
    .apb   (apb)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          acc;
    logic [3:0]  psel_setup;
    logic        pen_setup;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [3:0]  psel_or;
    logic        busy_ready;
    logic        hold_bad;
    logic        after_valid;
    logic        after_ready;
  } obs_t;

  typedef struct {
    logic        hit;
    int          port;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  // Transaction-level expectation: latency counted in cycles after the accept edge.
  function automatic exp_t model(input logic [31:0] a, input logic rd, input int waits,
                                 input logic se, input logic [31:0] prd);
    exp_t e;
    e.hit  = ((a >> (SEL_LSB_DEF + 2)) == 32'(BASE_HI_DEF));
    e.port = int'((a >> SEL_LSB_DEF) & 32'd3);
    if (!e.hit) begin
      e.lat = 1; e.err = 1'b1; e.rdata = 32'd0; e.acc = 0;
    end else if (waits < 0 || waits >= TO) begin
      e.lat = 2 + TO; e.err = 1'b1; e.rdata = 32'd0; e.acc = TO;
    end else begin
      e.lat = 3 + waits; e.err = se; e.rdata = (rd && !se) ? prd : 32'd0; e.acc = waits + 1;
    end
    return e;
  endfunction

  task automatic idle_inputs();
    icb.cmd_valid = 1'b0;
    icb.cmd_addr  = '0;
    icb.cmd_read  = 1'b0;
    icb.cmd_wdata = '0;
    icb.cmd_wmask = '0;
    icb.rsp_ready = 1'b1;
    apb.pready    = '0;
    apb.pslverr   = '0;
    apb.prdata    = '0;
  endtask

  // Drives one ICB command and plays the APB slave; returns what was observed.
  task automatic run_txn(input logic [31:0] a, input logic rd, input logic [31:0] wd,
                         input logic [3:0] wm, input int waits, input logic se,
                         input logic [31:0] prd, input logic noise, input int bp,
                         output obs_t o);
    int p;
    int acc;
    p = int'((a >> SEL_LSB_DEF) & 32'd3);
    o.lat = -1; o.rdata = '0; o.err = 1'b0; o.acc = 0; o.psel_setup = '0;
    o.pen_setup = 1'b0; o.paddr = '0; o.pwrite = 1'b0; o.pwdata = '0; o.pstrb = '0;
    o.psel_or = '0; o.busy_ready = 1'b0; o.hold_bad = 1'b0;
    o.after_valid = 1'b1; o.after_ready = 1'b0;
    @(negedge clk);
    icb.cmd_valid = 1'b1; icb.cmd_addr = a; icb.cmd_read = rd;
    icb.cmd_wdata = wd;   icb.cmd_wmask = wm; icb.rsp_ready = (bp == 0);
    @(posedge clk);
    acc = 0;
    for (int k = 1; k <= 64 && o.lat < 0; k++) begin
      @(negedge clk);
      icb.cmd_valid = 1'b0;
      if (k == 1) begin
        o.psel_setup = apb.psel;  o.pen_setup = apb.penable; o.paddr = apb.paddr;
        o.pwrite     = apb.pwrite; o.pwdata   = apb.pwdata;  o.pstrb = apb.pstrb;
      end
      o.psel_or    |= apb.psel;
      o.busy_ready |= icb.cmd_ready;
      if (icb.rsp_valid) begin
        o.lat = k; o.rdata = icb.rsp_rdata; o.err = icb.rsp_err;
      end else if (apb.penable) begin
        acc++;
      end
      apb.pready  = noise ? ~(4'b0001 << p) : 4'b0000;
      apb.pslverr = noise ? ~(4'b0001 << p) : 4'b0000;
      if (noise)
        for (int j = 0; j < 4; j++) if (j != p) apb.prdata[j] = $urandom;
      if (!icb.rsp_valid && apb.penable && apb.psel[p] && waits >= 0 && acc == waits + 1) begin
        apb.pready[p]  = 1'b1;
        apb.pslverr[p] = se;
        apb.prdata[p]  = prd;
      end
    end
    o.acc = acc;
    apb.pready = '0; apb.pslverr = '0;
    if (o.lat < 0) begin
      icb.rsp_ready = 1'b1;
      return;
    end
    for (int j = 0; j < bp; j++) begin
      @(negedge clk);
      if (icb.rsp_valid !== 1'b1 || icb.rsp_rdata !== o.rdata || icb.rsp_err !== o.err ||
          icb.cmd_ready !== 1'b0 || apb.psel !== 4'b0000)
        o.hold_bad = 1'b1;
    end
    icb.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o.after_valid = icb.rsp_valid;
    o.after_ready = icb.cmd_ready;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({icb.cmd_ready, icb.rsp_valid, icb.rsp_rdata, icb.rsp_err, apb.psel, apb.penable,
         apb.pwrite, apb.paddr, apb.pwdata, apb.pstrb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b psel=%b want all zero",
               icb.cmd_ready, icb.rsp_valid, icb.rsp_rdata, icb.rsp_err, apb.psel);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (icb.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b want 1", icb.cmd_ready);
    end
    checks++;
    if ({icb.rsp_valid, icb.rsp_err, apb.psel, apb.penable} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got valid=%b err=%b psel=%b penable=%b want 0",
               icb.rsp_valid, icb.rsp_err, apb.psel, apb.penable);
    end
  endtask

  task automatic test_write_zero_wait();
    obs_t o;
    run_txn(32'h1000_2004, 1'b0, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 1'b0, 0, o);
    checks++;
    if (o.psel_setup !== 4'b0100 || o.pen_setup !== 1'b0) begin
      errors++; $display("FAIL wr_setup: got psel=%b penable=%b want 0100/0", o.psel_setup, o.pen_setup);
    end
    checks++;
    if (o.acc !== 1) begin errors++; $display("FAIL wr_access_cycles: got %0d want 1", o.acc); end
    checks++;
    if (o.pstrb !== 4'hF || o.pwrite !== 1'b1 || o.paddr !== 32'h1000_2004 || o.pwdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_bus: got pstrb=%h pwrite=%b paddr=%h pwdata=%h want F/1/10002004/DEADBEEF",
               o.pstrb, o.pwrite, o.paddr, o.pwdata);
    end
    checks++;
    if (o.lat !== 3 || o.err !== 1'b0 || o.rdata !== 32'h0) begin
      errors++; $display("FAIL wr_rsp: got lat=%0d err=%b rdata=%h want 3/0/0", o.lat, o.err, o.rdata);
    end
  endtask

  task automatic test_read_wait_states();
    obs_t o;
    run_txn(32'h1000_3010, 1'b1, 32'h0, 4'h0, 3, 1'b0, 32'h1234_5678, 1'b0, 0, o);
    checks++;
    if (o.psel_setup !== 4'b1000 || o.pstrb !== 4'h0 || o.pwrite !== 1'b0) begin
      errors++; $display("FAIL rd_setup: got psel=%b pstrb=%h pwrite=%b want 1000/0/0", o.psel_setup, o.pstrb, o.pwrite);
    end
    checks++;
    if (o.lat !== 6 || o.err !== 1'b0 || o.rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL rd_rsp: got lat=%0d err=%b rdata=%h want 6/0/12345678", o.lat, o.err, o.rdata);
    end
  endtask

  task automatic test_decode_miss();
    obs_t o;
    run_txn(32'h2000_0000, 1'b1, 32'h0, 4'h0, 0, 1'b0, 32'hFFFF_FFFF, 1'b1, 0, o);
    checks++;
    if (o.psel_or !== 4'b0000) begin errors++; $display("FAIL miss_psel: got %b want 0000", o.psel_or); end
    checks++;
    if (o.lat !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
      errors++; $display("FAIL miss_rsp: got lat=%0d err=%b rdata=%h want 1/1/0", o.lat, o.err, o.rdata);
    end
  endtask

  task automatic test_pslverr();
    obs_t o;
    run_txn(32'h1000_1008, 1'b0, 32'hA5A5_0001, 4'h3, 1, 1'b1, 32'h0, 1'b0, 0, o);
    checks++;
    if (o.lat !== 4 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
      errors++; $display("FAIL slverr_rsp: got lat=%0d err=%b rdata=%h want 4/1/0", o.lat, o.err, o.rdata);
    end
    checks++;
    if (o.after_ready !== 1'b1 || o.after_valid !== 1'b0) begin
      errors++; $display("FAIL slverr_idle: got ready=%b valid=%b want 1/0", o.after_ready, o.after_valid);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(32'h1000_0040, 1'b1, 32'h0, 4'h0, -1, 1'b0, 32'h0, 1'b1, 0, o);
    checks++;
    if (o.acc !== TO) begin errors++; $display("FAIL to_access_cycles: got %0d want %0d", o.acc, TO); end
    checks++;
    if (o.lat !== 2 + TO || o.err !== 1'b1 || o.rdata !== 32'h0) begin
      errors++; $display("FAIL to_rsp: got lat=%0d err=%b rdata=%h want %0d/1/0", o.lat, o.err, o.rdata, 2 + TO);
    end
    run_txn(32'h1000_2100, 1'b1, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_F00D, 1'b0, 0, o);
    checks++;
    if (o.lat !== 3 || o.err !== 1'b0 || o.rdata !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL to_recover: got lat=%0d err=%b rdata=%h want 3/0/0BADF00D", o.lat, o.err, o.rdata);
    end
  endtask

  task automatic test_back_pressure_reset();
    obs_t o;
    logic seen;
    run_txn(32'h1000_1020, 1'b1, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_0001, 1'b0, 10, o);
    checks++;
    if (o.hold_bad !== 1'b0) begin errors++; $display("FAIL bp_hold: got unstable=%b want 0", o.hold_bad); end
    checks++;
    if (o.lat !== 3 || o.rdata !== 32'hCAFE_0001 || o.after_ready !== 1'b1) begin
      errors++; $display("FAIL bp_rsp: got lat=%0d rdata=%h ready_after=%b want 3/CAFE0001/1", o.lat, o.rdata, o.after_ready);
    end
    // Start a transfer whose slave never answers, then pull reset during ACCESS.
    @(negedge clk);
    icb.cmd_valid = 1'b1; icb.cmd_addr = 32'h1000_0000; icb.cmd_read = 1'b0;
    icb.cmd_wdata = 32'h1111_2222; icb.cmd_wmask = 4'hF;
    @(posedge clk);
    @(negedge clk) icb.cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (apb.penable !== 1'b1 || apb.psel !== 4'b0001) begin
      errors++; $display("FAIL rst_pre_access: got psel=%b penable=%b want 0001/1", apb.psel, apb.penable);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({icb.cmd_ready, icb.rsp_valid, icb.rsp_rdata, icb.rsp_err, apb.psel, apb.penable,
         apb.pwrite, apb.paddr, apb.pwdata, apb.pstrb} !== '0) begin
      errors++;
      $display("FAIL rst_async: got psel=%b penable=%b paddr=%h pwdata=%h valid=%b want all zero",
               apb.psel, apb.penable, apb.paddr, apb.pwdata, icb.rsp_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= icb.rsp_valid | (|apb.psel);
    end
    checks++;
    if (seen !== 1'b0 || icb.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_no_rsp: got activity=%b ready=%b want 0/1", seen, icb.cmd_ready);
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [31:0] a, wd, prd;
    logic rd, se, noise;
    logic [3:0] wm;
    int waits, port;
    for (int i = 0; i < 24; i++) begin
      port  = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0)
        a = {($urandom_range(0, 1) == 1) ? 4'h2 : 4'h0, 28'($urandom)};
      else
        a = {BASE_HI_DEF, 2'(port), 12'($urandom) & 12'hFFC};
      rd    = 1'($urandom);
      wd    = $urandom;
      wm    = 4'($urandom);
      waits = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      se    = ($urandom_range(0, 3) == 0);
      prd   = $urandom;
      noise = 1'($urandom);
      run_txn(a, rd, wd, wm, waits, se, prd, noise, int'($urandom_range(0, 2)), o);
      e = model(a, rd, waits, se, prd);
      checks++;
      if (o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata) begin
        errors++;
        $display("FAIL rnd%0d_rsp: addr=%h got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                 i, a, o.lat, o.err, o.rdata, e.lat, e.err, e.rdata);
      end
      checks++;
      if (o.acc !== e.acc || o.psel_or !== (e.hit ? (4'b0001 << e.port) : 4'b0000)) begin
        errors++;
        $display("FAIL rnd%0d_apb: addr=%h got acc=%0d psel_seen=%b want acc=%0d port=%0d hit=%b",
                 i, a, o.acc, o.psel_or, e.acc, e.port, e.hit);
      end
      if (e.hit) begin
        checks++;
        if (o.paddr !== a || o.pwrite !== !rd || o.pstrb !== (rd ? 4'h0 : wm) ||
            (!rd && o.pwdata !== wd) || o.pen_setup !== 1'b0) begin
          errors++;
          $display("FAIL rnd%0d_setup: got paddr=%h pwrite=%b pstrb=%h pwdata=%h pen=%b want %h/%b/%h/%h/0",
                   i, o.paddr, o.pwrite, o.pstrb, o.pwdata, o.pen_setup, a, !rd, rd ? 4'h0 : wm, wd);
        end
      end
      checks++;
      if (o.busy_ready !== 1'b0 || o.after_ready !== 1'b1 || o.after_valid !== 1'b0 || o.hold_bad !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_hs: got busy_ready=%b ready_after=%b valid_after=%b unstable=%b want 0/1/0/0",
                 i, o.busy_ready, o.after_ready, o.after_valid, o.hold_bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_decode_miss();
    test_pslverr();
    test_timeout();
    test_back_pressure_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/icb_apb_dispatcher.md
# icb_apb_dispatcher

Sequencing controller between the ICB slave front end and the four APB master channels of the crypto bridge. It accepts one ICB command at a time and decodes its address to one of four APB ports. It runs the APB SETUP/ACCESS handshake on that port and returns a single ICB response, with an APB-side timeout and a decode-error path. It sits inside the bridge top, between the ICB interface and the apb_bus_0..3 master ports.

## Interface
Parameters:
- ADDR_W, 32, ICB/APB address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- SEL_LSB, 12, LSB of the 2-bit port-select field addr[SEL_LSB+1:SEL_LSB]
- BASE_HI, 18'h04000, required value of addr[ADDR_W-1:SEL_LSB+2]; the default window is 0x1000_0000–0x1000_3FFF
- TIMEOUT, 255, maximum ACCESS-phase wait cycles before abort (1..2^16-1)

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accepted when high with valid
- icb_cmd_addr  in  ADDR_W  byte address
- icb_cmd_read  in  1  1 = read, 0 = write
- icb_cmd_wdata  in  DATA_W  write data
- icb_cmd_wmask  in  DATA_W/8  byte enables
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response accepted
- icb_rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- icb_rsp_err  out  1  decode error, pslverr or timeout
- psel  out  4  one-hot APB select, bit i = apb_bus_i
- penable  out  1  shared ACCESS-phase flag
- pwrite, paddr, pwdata, pstrb  out  1/ADDR_W/DATA_W/DATA_W/8  shared APB command bus
- prdata  in  4×DATA_W  per-port read data
- pready, pslverr  in  4 each  per-port completion and error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE:** icb_cmd_ready=1. On a handshake, latch addr, read, wdata and wmask, then decode.
  - Window hit: compute port = addr[SEL_LSB+1:SEL_LSB] and go to SETUP.
  - Window miss: set err=1, rdata=0, and go straight to RESP. No APB activity.
- **SETUP:** psel[port]=1, penable=0. Drive the latched paddr, pwrite=~read, pwdata and pstrb (pstrb=wmask on writes, 0 on reads). Go to ACCESS unconditionally.
- **ACCESS:** psel[port]=1 and penable=1; the wait counter increments each cycle.
  - pready[port]=1: capture prdata[port] (reads only) and err=pslverr[port], then go to RESP.
  - Counter reaches TIMEOUT with pready low: set err=1, rdata=0, drop psel/penable and go to RESP. The late transfer is abandoned.
- **RESP:** icb_rsp_valid=1, with rdata/err held stable. On icb_rsp_ready, go to IDLE.
- Only pready/pslverr/prdata of the selected port are observed. Other ports are ignored even if asserted.
- Exactly one outstanding transaction. icb_cmd_ready=0 in every state other than IDLE.
- The APB command bus holds its last values when psel=0. Verification must not check it while idle.

## Timing
- Reset values:
  - state = IDLE
  - icb_cmd_ready = 1 after reset deassertion, 0 during reset
  - icb_rsp_valid = 0, icb_rsp_rdata = 0, icb_rsp_err = 0
  - psel = 0, penable = 0, pwrite = 0, paddr = 0, pwdata = 0, pstrb = 0
  - wait counter = 0
- Zero-wait slave: handshake at cycle T, SETUP at T+1, ACCESS at T+2 (pready sampled), icb_rsp_valid at T+3. Next accept is no earlier than the cycle after the rsp handshake.
- N wait states: icb_rsp_valid at T+3+N.
- Decode miss: icb_rsp_valid at T+1.
- Timeout: pready is not sampled after ACCESS cycle TIMEOUT. icb_rsp_valid asserts the following cycle with err=1.
- The wait counter is 16 bits, cleared on entry to SETUP, and saturates (it does not wrap).
- A response back-pressured by icb_rsp_ready=0 holds indefinitely. The APB side stays idle meanwhile.
- rst_n asserted mid-transaction: all outputs go to reset values immediately (asynchronously). The in-flight transfer is dropped and no response is issued.

## Structure
- The shared package (bridge package) holds:
  - the FSM state enum (IDLE/SETUP/ACCESS/RESP)
  - the 2-bit port index type
  - the ICB command struct {addr, read, wdata, wmask}
  - the default BASE_HI/SEL_LSB constants used by both the bridge top and the testbench address map
- One natural sub-module: icb_apb_addr_decode. It is purely combinational, taking addr and producing {hit, port[1:0]}, and is reused by the scoreboard model.

## Test plan
- Write to 0x1000_2004, wdata 0xDEAD_BEEF, wmask 0xF, zero-wait slave:
  - psel=4'b0100 at T+1 with penable=0, then penable=1 at T+2.
  - pstrb=4'hF; rsp at T+3 with err=0 and rdata=0.
- Read from 0x1000_3010 with slave 3 inserting 3 wait states and prdata=0x1234_5678:
  - rsp at T+6 with rdata=0x1234_5678 and err=0.
- Read from 0x2000_0000 (window miss):
  - psel stays 0 throughout.
  - rsp at T+1 with err=1 and rdata=0.
- Write to port 1 with pslverr=1 on the completing cycle: rsp err=1, FSM back to IDLE after the handshake.
- TIMEOUT=8, port 0 never asserts pready:
  - penable drops after 8 ACCESS cycles.
  - Next cycle gives rsp err=1; a following command to port 2 completes normally.
- Back-pressure and reset:
  - Hold icb_rsp_ready=0 for 10 cycles: rsp stays stable and cmd_ready=0.
  - Then assert rst_n=0 during the ACCESS of a new transfer: all outputs reach reset values within the same cycle and no response appears.
